// File: rtl/rx_sync_4phase_if.sv
// Bundled-data link plus local valid/ready port for the four-phase receiver.
// master = transmitter/core side, slave = rx_sync_4phase.
interface rx_sync_4phase_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ack_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;

  modport master (
    output req_in, data_in, ready_in,
    input  ack_out, data_out, valid_out
  );

  modport slave (
    input  req_in, data_in, ready_in,
    output ack_out, data_out, valid_out
  );
endinterface

// File: rtl/rx_sync_4phase.sv
// Four-phase bundled-data receiver: req synchroniser, capture FSM, valid/ready output; RX_STATS_EN adds xfer_count.
// Latency: ack/valid SYNC_STAGES+1 edges after req_in rises; a full output buffer withholds ack.
module rx_sync_4phase #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rx_sync_4phase_if.slave      link,
  output logic                 busy
`ifdef RX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] xfer_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACK_HI = 2'b01,
    S_RETURN = 2'b10
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    req_s;
  logic                    ack_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;

  assign req_s          = sync_q[SYNC_STAGES-1];
  assign link.ack_out   = ack_q;
  assign link.valid_out = valid_q;
  assign link.data_out  = data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], link.req_in};
    end
  end

  // The pop and the capture are mutually exclusive: capture needs valid_q=0,
  // pop needs valid_q=1, so the capture assignment never overrides a pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy    <= 1'b0;
    end else begin
      if (valid_q && link.ready_in) begin
        valid_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          ack_q <= 1'b0;
          busy  <= 1'b0;
          if (req_s && !valid_q) begin
            data_q  <= link.data_in;
            valid_q <= 1'b1;
            ack_q   <= 1'b1;
            busy    <= 1'b1;
            state   <= S_ACK_HI;
          end
        end
        S_ACK_HI: begin
          ack_q <= 1'b1;
          busy  <= 1'b1;
          if (!req_s) begin
            ack_q <= 1'b0;
            state <= S_RETURN;
          end
        end
        S_RETURN: begin
          ack_q <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_count <= '0;
    end else if (state == S_ACK_HI && !req_s) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end
`else
  // Counter width only matters with statistics enabled.
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule
